// File: rtl/next_pc_gen_ftq_if.sv
// Bundle between the next-PC generator and its environment: redirect sources, predictor
// feedback, the predictor index (pcOut) and the fetch-target-queue head handshake.
//   master : the generator (drives pcOut and the ftq* head outputs)
//   slave  : predictor / recovery / fetch side (drives redirects, prediction, ftqReady)
interface next_pc_gen_ftq_if #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned SID_WIDTH   = 16,
  parameter int unsigned FTQ_DEPTH   = 4
);
  logic                           intValid;
  logic [PC_WIDTH-1:0]            intPC;
  logic                           cmRecValid;
  logic [PC_WIDTH-1:0]            cmRecPC;
  logic                           rnRecValid;
  logic [PC_WIDTH-1:0]            rnRecPC;
  logic                           predTaken;
  logic [$clog2(FETCH_WIDTH)-1:0] predSlot;
  logic [PC_WIDTH-1:0]            predTarget;
  logic                           brMispred;
  logic [PC_WIDTH-1:0]            pcOut;
  logic                           ftqValid;
  logic                           ftqReady;
  logic [PC_WIDTH-1:0]            ftqPC;
  logic [FETCH_WIDTH-1:0]         ftqMask;
  logic [SID_WIDTH-1:0]           ftqSID;
  logic [$clog2(FTQ_DEPTH):0]     ftqCount;

  modport master (
    input  intValid, intPC, cmRecValid, cmRecPC, rnRecValid, rnRecPC,
    input  predTaken, predSlot, predTarget, brMispred, ftqReady,
    output pcOut, ftqValid, ftqPC, ftqMask, ftqSID, ftqCount
  );

  modport slave (
    output intValid, intPC, cmRecValid, cmRecPC, rnRecValid, rnRecPC,
    output predTaken, predSlot, predTarget, brMispred, ftqReady,
    input  pcOut, ftqValid, ftqPC, ftqMask, ftqSID, ftqCount
  );
endinterface

// File: rtl/next_pc_gen_ftq.sv
// Next-PC generator feeding a fetch-target queue (FTQ).
// Each cycle a fetch block {start PC, lane mask, serial ID} is formed from the current PC and
// the predictor response, and pushed into a FTQ_DEPTH-entry ring that the fetch stage drains.
// Redirects (interrupt > commit recovery > rename recovery) flush the ring and reload the PC.
// Optional stop mode suppresses enqueue for MISPRED_WAIT cycles after a mispredict report.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-high reset
//   bus_io : next_pc_gen_ftq_if.master (redirects, prediction, pcOut, FTQ head handshake)
module next_pc_gen_ftq #(
  parameter int unsigned         FETCH_WIDTH     = 4,
  parameter int unsigned         INSN_BYTES      = 4,
  parameter int unsigned         LINE_BYTES      = 64,
  parameter int unsigned         PC_WIDTH        = 32,
  parameter int unsigned         FTQ_DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = PC_WIDTH'('h1000),
  parameter int unsigned         SID_WIDTH       = 16,
  parameter int unsigned         STOP_ON_MISPRED = 0,
  parameter int unsigned         MISPRED_WAIT    = 2
) (
  input logic               clk,
  input logic               rst,
  next_pc_gen_ftq_if.master bus_io
);

  localparam int unsigned OffW      = $clog2(LINE_BYTES);
  localparam int unsigned InsnShift = $clog2(INSN_BYTES);
  localparam int unsigned PtrW      = $clog2(FTQ_DEPTH);
  localparam int unsigned CntW      = PtrW + 1;
  localparam int unsigned NW        = $clog2(FETCH_WIDTH) + 1;
  localparam int unsigned WaitW     = (MISPRED_WAIT > 1) ? $clog2(MISPRED_WAIT + 1) : 1;

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [SID_WIDTH-1:0]   sid_q, sid_d;
  logic [PtrW-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [WaitW-1:0]       wait_q, wait_d;

  logic [PC_WIDTH-1:0]    pc_mem   [FTQ_DEPTH];
  logic [FETCH_WIDTH-1:0] mask_mem [FTQ_DEPTH];
  logic [SID_WIDTH-1:0]   sid_mem  [FTQ_DEPTH];

  logic [FETCH_WIDTH-1:0] mask_w;
  logic [NW-1:0]          n_w;
  logic                   redir, enq, deq, ftq_valid, full;
  logic [PC_WIDTH-1:0]    redir_pc;

  // Block formation: a lane is valid while it stays inside pc's cache line and does not lie
  // beyond a predicted-taken branch. Lane 0 always qualifies, so the mask is contiguous.
  always_comb begin
    mask_w = '0;
    n_w    = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if ((32'(pc_q[OffW-1:0]) + i * INSN_BYTES < LINE_BYTES) &&
          !(bus_io.predTaken && (i > 32'(bus_io.predSlot)))) begin
        mask_w[i] = 1'b1;
        n_w       = n_w + NW'(1);
      end
    end
  end

  always_comb begin
    redir = bus_io.intValid | bus_io.cmRecValid | bus_io.rnRecValid;
    if (bus_io.intValid) begin
      redir_pc = bus_io.intPC;
    end else if (bus_io.cmRecValid) begin
      redir_pc = bus_io.cmRecPC;
    end else begin
      redir_pc = bus_io.rnRecPC;
    end

    ftq_valid = (cnt_q != '0);
    full      = (cnt_q == CntW'(FTQ_DEPTH));
    deq       = ftq_valid & bus_io.ftqReady;
    enq       = !redir && (!full || deq) && (wait_q == '0);

    pc_d   = pc_q;
    sid_d  = sid_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    wait_d = wait_q;

    if (redir) begin
      // Flush: any same-cycle dequeue is dropped along with the rest of the queue.
      pc_d   = redir_pc;
      rd_d   = wr_q;
      cnt_d  = '0;
      wait_d = '0;
    end else begin
      if (enq) begin
        pc_d  = bus_io.predTaken ? bus_io.predTarget
                                 : pc_q + (PC_WIDTH'(n_w) << InsnShift);
        sid_d = sid_q + SID_WIDTH'(n_w);
        wr_d  = wr_q + 1'b1;
      end
      if (deq) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + CntW'(enq) - CntW'(deq);
      if ((STOP_ON_MISPRED != 0) && bus_io.brMispred) begin
        wait_d = WaitW'(MISPRED_WAIT);
      end else if (wait_q != '0) begin
        wait_d = wait_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      sid_q  <= SID_WIDTH'(1);
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      wait_q <= '0;
    end else begin
      pc_q   <= pc_d;
      sid_q  <= sid_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      wait_q <= wait_d;
    end
  end

  // Storage needs no reset: head outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_q]   <= pc_q;
      mask_mem[wr_q] <= mask_w;
      sid_mem[wr_q]  <= sid_q;
    end
  end

  assign bus_io.pcOut    = pc_q;
  assign bus_io.ftqValid = ftq_valid;
  assign bus_io.ftqCount = cnt_q;
  assign bus_io.ftqPC    = ftq_valid ? pc_mem[rd_q]   : '0;
  assign bus_io.ftqMask  = ftq_valid ? mask_mem[rd_q] : '0;
  assign bus_io.ftqSID   = ftq_valid ? sid_mem[rd_q]  : '0;

endmodule

// File: tb/tb_next_pc_gen_ftq.sv
module tb_next_pc_gen_ftq;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  mask;
    logic [15:0] sid;
  } blk_t;

  logic clk;
  logic rst;
  logic rst2;

  int checks = 0;
  int errors = 0;
  int pops1  = 0;
  int pops2  = 0;

  blk_t exp1[$];
  blk_t exp2[$];

  next_pc_gen_ftq_if #(.FETCH_WIDTH(4), .PC_WIDTH(32), .SID_WIDTH(16), .FTQ_DEPTH(4)) b1 ();
  next_pc_gen_ftq_if #(.FETCH_WIDTH(4), .PC_WIDTH(32), .SID_WIDTH(16), .FTQ_DEPTH(4)) b2 ();

  next_pc_gen_ftq u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (b1)
  );

  next_pc_gen_ftq #(.STOP_ON_MISPRED(1), .MISPRED_WAIT(2)) u_stop (
    .clk    (clk),
    .rst    (rst2),
    .bus_io (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic blk_t mk(input logic [31:0] pc, input logic [3:0] m, input logic [15:0] s);
    blk_t b;
    b.pc   = pc;
    b.mask = m;
    b.sid  = s;
    return b;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitors: a handshake without a same-cycle redirect is a real dequeue; pop and compare.
  always @(negedge clk) begin
    if (!rst && b1.ftqValid && b1.ftqReady && !(b1.intValid || b1.cmRecValid || b1.rnRecValid))
    begin
      pops1++;
      if (exp1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main_unexpected_head: got pc 0x%0h expected no head", b1.ftqPC);
      end else begin
        blk_t e;
        e = exp1.pop_front();
        check("main_head_pc", b1.ftqPC, e.pc);
        check("main_head_mask", 32'(b1.ftqMask), 32'(e.mask));
        check("main_head_sid", 32'(b1.ftqSID), 32'(e.sid));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst2 && b2.ftqValid && b2.ftqReady && !(b2.intValid || b2.cmRecValid || b2.rnRecValid))
    begin
      pops2++;
      if (exp2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stop_unexpected_head: got pc 0x%0h expected no head", b2.ftqPC);
      end else begin
        blk_t e;
        e = exp2.pop_front();
        check("stop_head_pc", b2.ftqPC, e.pc);
        check("stop_head_mask", 32'(b2.ftqMask), 32'(e.mask));
        check("stop_head_sid", 32'(b2.ftqSID), 32'(e.sid));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    rst2 = 1'b1;
    {b1.intValid, b1.cmRecValid, b1.rnRecValid, b1.predTaken, b1.brMispred} = '0;
    {b2.intValid, b2.cmRecValid, b2.rnRecValid, b2.predTaken, b2.brMispred} = '0;
    b1.intPC = '0; b1.cmRecPC = '0; b1.rnRecPC = '0; b1.predTarget = '0; b1.predSlot = '0;
    b2.intPC = '0; b2.cmRecPC = '0; b2.rnRecPC = '0; b2.predTarget = '0; b2.predSlot = '0;
    b1.ftqReady = 1'b1;
    b2.ftqReady = 1'b1;
    tick(3);

    check("rst_valid", 32'(b1.ftqValid), 32'd0);
    check("rst_count", 32'(b1.ftqCount), 32'd0);
    check("rst_pcout", b1.pcOut, 32'h1000);
    check("rst_ftqpc", b1.ftqPC, 32'h0);
    check("rst_mask", 32'(b1.ftqMask), 32'h0);
    check("rst_sid", 32'(b1.ftqSID), 32'h0);

    // Sequential fetch from reset
    rst = 1'b0;
    exp1.push_back(mk(32'h1000, 4'hF, 16'd1));
    exp1.push_back(mk(32'h1010, 4'hF, 16'd5));
    exp1.push_back(mk(32'h1020, 4'hF, 16'd9));
    exp1.push_back(mk(32'h1030, 4'hF, 16'd13));
    tick(2);
    check("stream_count", 32'(b1.ftqCount), 32'd1);
    tick(2);

    // Line-end truncation
    b1.rnRecValid = 1'b1;
    b1.rnRecPC    = 32'h1038;
    exp1.delete();
    exp1.push_back(mk(32'h1038, 4'h3, 16'd17));
    exp1.push_back(mk(32'h1040, 4'hF, 16'd19));
    exp1.push_back(mk(32'h1050, 4'hF, 16'd23));
    tick(1);
    b1.rnRecValid = 1'b0;
    check("line_pcout", b1.pcOut, 32'h1038);
    tick(1);
    check("line_next_pc", b1.pcOut, 32'h1040);
    tick(2);

    // Predicted-taken branch in lane 1
    b1.cmRecValid = 1'b1;
    b1.cmRecPC    = 32'h1000;
    exp1.delete();
    exp1.push_back(mk(32'h1000, 4'h3, 16'd27));
    exp1.push_back(mk(32'h2000, 4'hF, 16'd29));
    exp1.push_back(mk(32'h2010, 4'hF, 16'd33));
    tick(1);
    b1.cmRecValid = 1'b0;
    b1.predTaken  = 1'b1;
    b1.predSlot   = 2'd1;
    b1.predTarget = 32'h2000;
    check("pred_pcout", b1.pcOut, 32'h1000);
    tick(1);
    b1.predTaken = 1'b0;
    check("pred_target", b1.pcOut, 32'h2000);
    tick(2);

    // Backpressure fills the queue, then drains in order
    b1.intValid = 1'b1;
    b1.intPC    = 32'h1000;
    b1.ftqReady = 1'b0;
    exp1.delete();
    exp1.push_back(mk(32'h1000, 4'hF, 16'd37));
    exp1.push_back(mk(32'h1010, 4'hF, 16'd41));
    exp1.push_back(mk(32'h1020, 4'hF, 16'd45));
    exp1.push_back(mk(32'h1030, 4'hF, 16'd49));
    exp1.push_back(mk(32'h1040, 4'hF, 16'd53));
    exp1.push_back(mk(32'h1050, 4'hF, 16'd57));
    tick(1);
    b1.intValid = 1'b0;
    tick(4);
    check("full_count", 32'(b1.ftqCount), 32'd4);
    check("full_pc_hold", b1.pcOut, 32'h1040);
    tick(1);
    check("full_count_hold", 32'(b1.ftqCount), 32'd4);
    check("full_pc_hold2", b1.pcOut, 32'h1040);
    b1.ftqReady = 1'b1;
    tick(1);
    check("full_deq_enq_count", 32'(b1.ftqCount), 32'd4);
    tick(4);

    // Simultaneous interrupt and commit recovery with a dequeue
    b1.intValid   = 1'b1;
    b1.intPC      = 32'h8000;
    b1.cmRecValid = 1'b1;
    b1.cmRecPC    = 32'h9000;
    exp1.delete();
    exp1.push_back(mk(32'h8000, 4'hF, 16'd73));
    exp1.push_back(mk(32'h8010, 4'hF, 16'd77));
    exp1.push_back(mk(32'h8020, 4'hF, 16'd81));
    tick(1);
    b1.intValid   = 1'b0;
    b1.cmRecValid = 1'b0;
    check("prio_count", 32'(b1.ftqCount), 32'd0);
    check("prio_pcout", b1.pcOut, 32'h8000);
    check("prio_valid", 32'(b1.ftqValid), 32'd0);
    tick(1);
    check("prio_head_valid", 32'(b1.ftqValid), 32'd1);
    check("empty_ready_count", 32'(b1.ftqCount), 32'd1);
    tick(2);

    // Asynchronous reset mid-operation
    exp1.delete();
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(b1.ftqValid), 32'd0);
    check("arst_count", 32'(b1.ftqCount), 32'd0);
    check("arst_pcout", b1.pcOut, 32'h1000);
    check("arst_sid", 32'(b1.ftqSID), 32'd0);
    check("main_pops", 32'(pops1), 32'd14);

    // Stop-on-mispredict instance
    tick(1);
    rst2 = 1'b0;
    exp2.push_back(mk(32'h1000, 4'hF, 16'd1));
    exp2.push_back(mk(32'h1010, 4'hF, 16'd5));
    exp2.push_back(mk(32'h1020, 4'hF, 16'd9));
    exp2.push_back(mk(32'h1030, 4'hF, 16'd13));
    exp2.push_back(mk(32'h1040, 4'hF, 16'd17));
    tick(1);
    b2.brMispred = 1'b1;
    tick(1);
    b2.brMispred = 1'b0;
    check("stop_pc_hold", b2.pcOut, 32'h1020);
    tick(1);
    check("stop_empty_valid", 32'(b2.ftqValid), 32'd0);
    check("stop_empty_count", 32'(b2.ftqCount), 32'd0);
    tick(1);
    check("stop_still_empty", 32'(b2.ftqValid), 32'd0);
    tick(1);
    check("stop_resume_valid", 32'(b2.ftqValid), 32'd1);
    tick(1);
    b2.brMispred = 1'b1;
    tick(1);
    b2.brMispred  = 1'b0;
    b2.rnRecValid = 1'b1;
    b2.rnRecPC    = 32'h4000;
    exp2.delete();
    exp2.push_back(mk(32'h4000, 4'hF, 16'd21));
    exp2.push_back(mk(32'h4010, 4'hF, 16'd25));
    tick(1);
    b2.rnRecValid = 1'b0;
    check("stop_redir_pcout", b2.pcOut, 32'h4000);
    check("stop_redir_valid", 32'(b2.ftqValid), 32'd0);
    tick(1);
    check("stop_redir_head", 32'(b2.ftqValid), 32'd1);
    tick(1);
    rst2 = 1'b1;
    #1;
    check("stop_pops", 32'(pops2), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
